// File: rtl/mem_pkg.sv
// Shared definitions for the 16x16 memory request controller.
// Opcodes, default widths and the controller state encoding.
package mem_pkg;

   localparam int MEM_DATA_W = 16;
   localparam int MEM_ADDR_W = 4;

   localparam logic [2:0] OP_WAIT  = 3'd0;
   localparam logic [2:0] OP_READ  = 3'd1;
   localparam logic [2:0] OP_WRITE = 3'd2;
   localparam logic [2:0] OP_CLEAR = 3'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } ctrl_state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return (op == OP_READ) || (op == OP_WRITE) || (op == OP_CLEAR);
   endfunction

endpackage

// File: rtl/mem_req_timeout.sv
// BUSY watchdog counter for mem_req_ctrl (used under MEM_REQ_TIMEOUT_EN).
// o_expired flags the edge on which the count would reach TIMEOUT_CYCLES.
module mem_req_timeout #(
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != LIMIT)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/mem_req_ctrl.sv
// Request controller in front of the 16x16 memory block.
// Optional BUSY timeout abort is built when MEM_REQ_TIMEOUT_EN is defined.
module mem_req_ctrl
   import mem_pkg::*;
#(
   parameter int DATA_W         = MEM_DATA_W,
   parameter int ADDR_W         = MEM_ADDR_W,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_error,
   output logic [2:0]        mem_operation,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   input  logic              mem_done,
   output logic              busy
);

   ctrl_state_t       r_state;
   logic              r_resp_valid;
   logic              r_resp_error;
   logic [DATA_W-1:0] r_resp_rdata;
   logic [2:0]        r_mem_op;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_din;

   logic w_accept;
   logic w_wait;
   logic w_expired;

   assign req_ready = (r_state == IDLE) && !rst;
   assign w_accept  = req_valid && req_ready;
   assign w_wait    = (r_state == BUSY) && !mem_done;
   assign busy      = (r_state != IDLE);

`ifdef MEM_REQ_TIMEOUT_EN
   mem_req_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_accept),
      .i_en     (w_wait),
      .o_expired(w_expired)
   );
`else
   logic w_unused_timeout;
   assign w_unused_timeout = w_wait ^ (TIMEOUT_CYCLES == 0);
   assign w_expired = 1'b0;
`endif

   // Illegal ops bypass the memory: an op of 4-7 would park it in decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_resp_valid <= 1'b0;
         r_resp_error <= 1'b0;
         r_resp_rdata <= '0;
         r_mem_op     <= OP_WAIT;
         r_mem_addr   <= '0;
         r_mem_din    <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (req_valid) begin
                  if (op_legal(req_op)) begin
                     r_mem_op   <= req_op;
                     r_mem_addr <= req_addr;
                     r_mem_din  <= req_wdata;
                     r_state    <= BUSY;
                  end else begin
                     r_resp_rdata <= '0;
                     r_resp_error <= 1'b1;
                     r_resp_valid <= 1'b1;
                     r_state      <= RESP;
                  end
               end
            end
            BUSY: begin
               if (mem_done) begin
                  r_resp_rdata <= (r_mem_op == OP_READ) ? mem_data_out : '0;
                  r_resp_error <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_mem_op     <= OP_WAIT;
                  r_state      <= RESP;
               end else if (w_expired) begin
                  r_resp_rdata <= '0;
                  r_resp_error <= 1'b1;
                  r_resp_valid <= 1'b1;
                  r_mem_op     <= OP_WAIT;
                  r_state      <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign resp_valid    = r_resp_valid;
   assign resp_error    = r_resp_error;
   assign resp_rdata    = r_resp_rdata;
   assign mem_operation = r_mem_op;
   assign mem_address   = r_mem_addr;
   assign mem_data_in   = r_mem_din;

endmodule
